// File: rtl/memory.sv
// ---------------------------------------------------------------------------
// memory -- operand/operator storage for the BCD calculator datapath.
//
// Builds operand 1 (save1) and operand 2 (save2) from keypad digits by a
// BCD left shift, latches the selected operator (shown one-hot on op_out)
// and reloads save1 with the ALU result on "=" so results can be chained.
// No arithmetic is done here; data stays BCD throughout.
//
// Ports:
//   clk           in   1  system clock, rising edge
//   rst           in   1  asynchronous active-high reset
//   num           in   4  keypad digit (BCD); 10..15 are ignored
//   res           in   W  ALU result (BCD), loaded on equ_enable
//   operator      in   2  00 add, 01 sub, 10 mul, 11 div
//   clear_enable  in   1  synchronous clear of all stored state
//   equ_enable    in   1  "=": save1<=res, save2<=0, operator cleared
//   save_enable   in   2  01 digit->save1, 11 digit->save2, 10 latch op
//   op_enable     in   1  latch operator regardless of save_enable
//   save1         out  W  operand 1
//   save2         out  W  operand 2
//   op_out        out  4  one-hot operator, 0000 when none stored
//
// Configuration macro MEM_DIGIT_LIMIT_EN:
//   defined   -> digits entered into a full operand are ignored
//                (the first NUM_DIGITS digits are kept)
//   undefined -> entry always shifts, dropping the most significant digit
// ---------------------------------------------------------------------------
module memory #(
    parameter int NUM_DIGITS = 4,
    parameter int W          = 4 * NUM_DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   num,
    input  logic [W-1:0] res,
    input  logic [1:0]   operator,
    input  logic         clear_enable,
    input  logic         equ_enable,
    input  logic [1:0]   save_enable,
    input  logic         op_enable,
    output logic [W-1:0] save1,
    output logic [W-1:0] save2,
    output logic [3:0]   op_out
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);

    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;

    logic digit_ok;
    logic wr1;
    logic wr2;
    logic op_latch;

    function automatic logic [3:0] onehot(input logic [1:0] code);
        logic [3:0] r;
        r = 4'b0000;
        r[code] = 1'b1;
        return r;
    endfunction

    assign digit_ok = (num <= 4'd9);

    // With the digit limit enabled, a full operand refuses further digits.
`ifdef MEM_DIGIT_LIMIT_EN
    assign wr1 = digit_ok && (save_enable == 2'b01) && (cnt1 != CNT_FULL);
    assign wr2 = digit_ok && (save_enable == 2'b11) && (cnt2 != CNT_FULL);
`else
    assign wr1 = digit_ok && (save_enable == 2'b01);
    assign wr2 = digit_ok && (save_enable == 2'b11);
`endif

    assign op_latch = (save_enable == 2'b10) || op_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            save1  <= '0;
            save2  <= '0;
            op_out <= '0;
            cnt1   <= '0;
            cnt2   <= '0;
        end else if (clear_enable) begin
            save1  <= '0;
            save2  <= '0;
            op_out <= '0;
            cnt1   <= '0;
            cnt2   <= '0;
        end else if (equ_enable) begin
            // Result becomes a full-length operand 1 for chaining.
            save1  <= res;
            cnt1   <= CNT_FULL;
            save2  <= '0;
            cnt2   <= '0;
            op_out <= '0;
        end else begin
            if (wr1) begin
                save1 <= {save1[W-5:0], num};
                if (cnt1 != CNT_FULL) cnt1 <= cnt1 + 1'b1;
            end
            if (wr2) begin
                save2 <= {save2[W-5:0], num};
                if (cnt2 != CNT_FULL) cnt2 <= cnt2 + 1'b1;
            end
            // Operator latch may coincide with a digit entry.
            if (op_latch) op_out <= onehot(operator);
        end
    end

endmodule

// File: tb/tb_memory.sv
module tb_memory;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   num;
    logic [W-1:0] res;
    logic [1:0]   operator;
    logic         clear_enable;
    logic         equ_enable;
    logic [1:0]   save_enable;
    logic         op_enable;
    logic [W-1:0] save1;
    logic [W-1:0] save2;
    logic [3:0]   op_out;

    int errors = 0;
    int checks = 0;

    memory #(.NUM_DIGITS(N)) dut (
        .clk(clk), .rst(rst), .num(num), .res(res), .operator(operator),
        .clear_enable(clear_enable), .equ_enable(equ_enable),
        .save_enable(save_enable), .op_enable(op_enable),
        .save1(save1), .save2(save2), .op_out(op_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         clr;
        logic         equ;
        logic [1:0]   se;
        logic         ope;
        logic [3:0]   num;
        logic [1:0]   op;
        logic [W-1:0] res;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [3:0]   eo;
    } vec_t;

    vec_t tbl[12];

    // Reference model: operands as lists of decimal digits, most significant first.
    int q1[$];
    int q2[$];
    int opm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] qval(input int q[$]);
        logic [W-1:0] v;
        v = '0;
        foreach (q[i]) v = v * 16 + W'(q[i]);
        return v;
    endfunction

    function automatic logic [3:0] op_exp();
        return (opm < 0) ? 4'b0000 : 4'(1 << opm);
    endfunction

    task automatic push_digit(inout int q[$], input int d);
`ifdef MEM_DIGIT_LIMIT_EN
        if (q.size() < N) q.push_back(d);
`else
        q.push_back(d);
        if (q.size() > N) void'(q.pop_front());
`endif
    endtask

    task automatic model_step();
        if (clear_enable) begin
            q1 = {}; q2 = {}; opm = -1;
        end else if (equ_enable) begin
            q1 = {};
            for (int i = N - 1; i >= 0; i--) q1.push_back(int'((res >> (4 * i)) & 16'hF));
            q2 = {}; opm = -1;
        end else begin
            if (num < 10 && save_enable == 2'b01) push_digit(q1, int'(num));
            if (num < 10 && save_enable == 2'b11) push_digit(q2, int'(num));
            if (save_enable == 2'b10 || op_enable) opm = int'(operator);
        end
    endtask

    task automatic idle();
        clear_enable = 0; equ_enable = 0; save_enable = 2'b00; op_enable = 0;
        num = 0; operator = 0; res = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string n, input logic c, input logic e, input logic [1:0] s,
                                input logic o, input logic [3:0] d, input logic [1:0] op,
                                input logic [W-1:0] r, input logic [W-1:0] e1,
                                input logic [W-1:0] e2, input logic [3:0] eo);
        vec_t v;
        v.name = n; v.clr = c; v.equ = e; v.se = s; v.ope = o; v.num = d; v.op = op;
        v.res = r; v.e1 = e1; v.e2 = e2; v.eo = eo;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk("dig1",      0, 0, 2'b01, 0, 4'd1, 2'd0, 16'h0,    16'h0001, 16'h0000, 4'b0000);
        tbl[1]  = mk("dig2",      0, 0, 2'b01, 0, 4'd2, 2'd0, 16'h0,    16'h0012, 16'h0000, 4'b0000);
        tbl[2]  = mk("bad_digit", 0, 0, 2'b01, 0, 4'hC, 2'd0, 16'h0,    16'h0012, 16'h0000, 4'b0000);
        tbl[3]  = mk("s2_dig5",   0, 0, 2'b11, 0, 4'd5, 2'd0, 16'h0,    16'h0012, 16'h0005, 4'b0000);
        tbl[4]  = mk("op_div",    0, 0, 2'b10, 0, 4'd0, 2'd3, 16'h0,    16'h0012, 16'h0005, 4'b1000);
        tbl[5]  = mk("dig+op",    0, 0, 2'b01, 1, 4'd3, 2'd1, 16'h0,    16'h0123, 16'h0005, 4'b0010);
        tbl[6]  = mk("equ",       0, 1, 2'b01, 1, 4'd4, 2'd2, 16'h9ABC, 16'h9ABC, 16'h0000, 4'b0000);
        tbl[7]  = mk("s2_dig7",   0, 0, 2'b11, 0, 4'd7, 2'd0, 16'h0,    16'h9ABC, 16'h0007, 4'b0000);
        tbl[8]  = mk("clr+equ",   1, 1, 2'b01, 1, 4'd1, 2'd1, 16'h1111, 16'h0000, 16'h0000, 4'b0000);
        tbl[9]  = mk("op_add",    0, 0, 2'b10, 0, 4'd0, 2'd0, 16'h0,    16'h0000, 16'h0000, 4'b0001);
        tbl[10] = mk("s2+op_mul", 0, 0, 2'b11, 1, 4'd9, 2'd2, 16'h0,    16'h0000, 16'h0009, 4'b0100);
        tbl[11] = mk("clear",     1, 0, 2'b00, 0, 4'd0, 2'd0, 16'h0,    16'h0000, 16'h0000, 4'b0000);

        idle();
        rst = 1;
        tick(); tick();
        chk("reset_save1", save1, 16'h0);
        chk("reset_save2", save2, 16'h0);
        chk("reset_op", op_out, 4'h0);
        rst = 0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            clear_enable = tbl[i].clr; equ_enable = tbl[i].equ; save_enable = tbl[i].se;
            op_enable = tbl[i].ope; num = tbl[i].num; operator = tbl[i].op; res = tbl[i].res;
            tick();
            chk({tbl[i].name, "_save1"}, save1, tbl[i].e1);
            chk({tbl[i].name, "_save2"}, save2, tbl[i].e2);
            chk({tbl[i].name, "_op"}, op_out, tbl[i].eo);
        end
        idle();

        // Six digits into save1 after a reset pulse
        rst = 1; tick(); rst = 0;
        save_enable = 2'b01;
        for (int d = 1; d <= 6; d++) begin
            num = 4'(d);
            tick();
        end
        idle();
`ifdef MEM_DIGIT_LIMIT_EN
        chk("six_digits", save1, 16'h1234);
`else
        chk("six_digits", save1, 16'h3456);
`endif
        // Chained entry after "=": result counts as a full operand
        res = 16'h0042; equ_enable = 1; tick(); idle();
        save_enable = 2'b01; num = 4'd7; tick(); idle();
`ifdef MEM_DIGIT_LIMIT_EN
        chk("after_equ_digit", save1, 16'h0042);
`else
        chk("after_equ_digit", save1, 16'h0427);
`endif
        // Held enable repeats the action every edge
        save_enable = 2'b11; num = 4'd8; tick(); tick(); tick(); idle();
        chk("held_enable", save2, 16'h0888);

        // Asynchronous reset mid-cycle
        save_enable = 2'b01; num = 4'd5; operator = 2'd1; op_enable = 1; tick(); idle();
        #2 rst = 1;
        #1;
        chk("async_rst_save1", save1, 16'h0);
        chk("async_rst_save2", save2, 16'h0);
        chk("async_rst_op", op_out, 4'h0);
        @(negedge clk);
        rst = 0;

        // Randomized run against the digit-list model
        q1 = {}; q2 = {}; opm = -1;
        for (int c = 0; c < 400; c++) begin
            logic [W-1:0] r;
            r = '0;
            for (int k = 0; k < N; k++) r = r * 16 + W'($urandom_range(0, 9));
            clear_enable = ($urandom_range(0, 24) == 0);
            equ_enable   = ($urandom_range(0, 14) == 0);
            save_enable  = 2'($urandom_range(0, 3));
            op_enable    = ($urandom_range(0, 3) == 0);
            num          = 4'($urandom_range(0, 15));
            operator     = 2'($urandom_range(0, 3));
            res          = r;
            model_step();
            tick();
            chk("rnd_save1", save1, qval(q1));
            chk("rnd_save2", save2, qval(q2));
            chk("rnd_op", op_out, op_exp());
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
